// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared types and constants for the LED animation engine.
// Mode encodings match the board-level mode selector.
package led_anim_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_CHASE   = 2'd0;
  localparam mode_t MODE_FILL    = 2'd1;
  localparam mode_t MODE_BOUNCE  = 2'd2;
  localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_animator_if.sv
// led_animator_if: mode/period controls in, LED drive and frame pulse out.
// master drives the controls, slave is the animator.
interface led_animator_if #(
  parameter int N_LEDS = 8,
  parameter int STEP_W = 16
) ();
  import led_anim_pkg::*;

  mode_t              mode;
  logic [STEP_W-1:0]  step_period;
  logic [N_LEDS-1:0]  led_out;
  logic               frame_done;

  modport master (
    output mode,
    output step_period,
    input  led_out,
    input  frame_done
  );

  modport slave (
    input  mode,
    input  step_period,
    output led_out,
    output frame_done
  );

endinterface

// File: rtl/led_step_timer.sv
// led_step_timer: programmable step tick, period 0 behaves as 1.
// Count compares with >= so a lowered period fires on the next cycle.
module led_step_timer #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [STEP_W-1:0] period,
  output logic              tick
);

  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] last;

  // last count value of a step, with period 0 clamped to 1
  always_comb begin
    last = '0;
    if (period != '0)
      last = period - STEP_W'(1);
  end

  assign tick = !clear && (cnt >= last);

  // step counter, cleared by restart/mode change and on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + STEP_W'(1);
  end

endmodule

// File: rtl/led_animator.sv
// led_animator: chase, fill/drain, bounce and PWM breathe LED engine.
// Mode change blanks for one cycle, then restart loads the first pattern.
module led_animator
  import led_anim_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int STEP_W = 16,
  parameter int PWM_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_animator_if.slave bus
);

  localparam int IDX_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;

  localparam logic [PWM_W-1:0]  D_MAX   = {PWM_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] LSB     = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] MSB     = LSB << (N_LEDS - 1);
  localparam logic [N_LEDS-1:0] ALL     = '1;

  mode_t             mode_r,    mode_nx;
  logic              restart,   restart_nx;
  logic [N_LEDS-1:0] led_r,     led_nx;
  logic              fd_r,      fd_nx;
  logic              dir_up,    dir_nx;
  logic              b_left,    b_left_nx;
  logic [PWM_W-1:0]  duty,      duty_nx;
  logic [IDX_W-1:0]  idx,       idx_nx;
  logic [PWM_W-1:0]  pwm_cnt;

  logic mode_chg;
  logic tick;
  logic pwm;

  assign mode_chg = (bus.mode != mode_r);
  assign pwm      = (pwm_cnt < duty);

  led_step_timer #(
    .STEP_W (STEP_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (mode_chg || restart),
    .period (bus.step_period),
    .tick   (tick)
  );

  // next-state for mode tracking, pattern and breathe state
  always_comb begin
    mode_nx    = mode_r;
    restart_nx = restart;
    led_nx     = led_r;
    fd_nx      = 1'b0;
    dir_nx     = dir_up;
    b_left_nx  = b_left;
    duty_nx    = duty;
    idx_nx     = idx;

    if (mode_chg) begin
      mode_nx    = bus.mode;
      led_nx     = '0;
      restart_nx = 1'b1;
    end else if (restart) begin
      restart_nx = 1'b0;
      dir_nx     = 1'b1;
      b_left_nx  = 1'b0;
      duty_nx    = '0;
      idx_nx     = IDX_TOP;
      led_nx     = (mode_r == MODE_BREATHE) ? '0 : MSB;
    end else begin
      unique case (mode_r)
        MODE_CHASE: begin
          if (tick) begin
            if (led_r == LSB) begin
              led_nx = MSB;
              fd_nx  = 1'b1;
            end else begin
              led_nx = led_r >> 1;
            end
          end
        end

        MODE_FILL: begin
          // dir_up doubles as the fill phase flag
          if (tick) begin
            if (led_r == '0) begin
              led_nx = MSB;
              dir_nx = 1'b1;
              fd_nx  = 1'b1;
            end else if (dir_up && led_r != ALL) begin
              led_nx = {1'b1, led_r[N_LEDS-1:1]};
            end else begin
              led_nx = led_r >> 1;
              dir_nx = 1'b0;
            end
          end
        end

        MODE_BOUNCE: begin
          if (tick) begin
            if (!b_left) begin
              led_nx = led_r >> 1;
              if (led_r[1])
                b_left_nx = 1'b1;
            end else begin
              led_nx = led_r << 1;
              if (led_r[N_LEDS-2]) begin
                b_left_nx = 1'b0;
                fd_nx     = 1'b1;
              end
            end
          end
        end

        MODE_BREATHE: begin
          led_nx = pwm ? (LSB << idx) : '0;
          if (tick) begin
            if (dir_up) begin
              if (duty == D_MAX) begin
                duty_nx = D_MAX - PWM_W'(1);
                dir_nx  = 1'b0;
              end else begin
                duty_nx = duty + PWM_W'(1);
              end
            end else if (duty != '0) begin
              duty_nx = duty - PWM_W'(1);
            end else begin
              dir_nx = 1'b1;
              if (idx == '0) begin
                idx_nx = IDX_TOP;
                fd_nx  = 1'b1;
              end else begin
                idx_nx = idx - IDX_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  // animation state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= MODE_CHASE;
      restart <= 1'b1;
      led_r   <= '0;
      fd_r    <= 1'b0;
      dir_up  <= 1'b1;
      b_left  <= 1'b0;
      duty    <= '0;
      idx     <= IDX_TOP;
    end else begin
      mode_r  <= mode_nx;
      restart <= restart_nx;
      led_r   <= led_nx;
      fd_r    <= fd_nx;
      dir_up  <= dir_nx;
      b_left  <= b_left_nx;
      duty    <= duty_nx;
      idx     <= idx_nx;
    end
  end

  // free-running PWM counter, wraps at D_MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign bus.led_out    = led_r;
  assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_led_animator.sv
// tb_led_animator: scoreboard bench for led_animator (N=8, PWM_W=4).
// Expected per-cycle LED/frame values are queued, then compared each negedge.
module tb_led_animator;
  import led_anim_pkg::*;

  localparam int N  = 8;
  localparam int SW = 16;
  localparam int PW = 4;

  typedef struct packed {
    logic [7:0] led;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int unsigned edge_cnt;

  always #5 clk = ~clk;

  led_animator_if #(.N_LEDS(N), .STEP_W(SW)) bus ();

  led_animator #(
    .N_LEDS (N),
    .STEP_W (SW),
    .PWM_W  (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // edges since reset release, i.e. the free-running PWM phase
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic push(input logic [7:0] led, input logic fd, input int n);
    exp_t e;
    e.led = led;
    e.fd  = fd;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic run_check(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.led_out !== e.led || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s t=%0t: led_out=%h frame_done=%b, expected led_out=%h frame_done=%b",
                 tag, $time, bus.led_out, bus.frame_done, e.led, e.fd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mode = MODE_CHASE;
    bus.step_period = 16'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.led_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: led_out=%h frame_done=%b, expected 00/0",
               bus.led_out, bus.frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_chase();
    logic [7:0] v;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) begin
        v = 8'h80 >> i;
        push(v, (f == 1 && i == 0), 1);
        push(v, 1'b0, 2);
      end
    push(8'h80, 1'b1, 1);
    run_check("chase");
  endtask

  task automatic test_fill();
    logic [7:0] v;
    bus.mode = MODE_FILL;
    bus.step_period = 16'd1;
    push(8'h00, 1'b0, 1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        v = 8'hFF >> (i + 1);
        v = ~v;
        push(v, (f == 1 && i == 0), 1);
      end
      for (int i = 0; i < 8; i++) begin
        v = 8'hFF >> (i + 1);
        push(v, 1'b0, 1);
      end
    end
    push(8'h80, 1'b1, 1);
    run_check("fill");
  endtask

  task automatic test_bounce();
    logic [7:0] v;
    bus.mode = MODE_BOUNCE;
    bus.step_period = 16'd2;
    push(8'h00, 1'b0, 1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        v = 8'h80 >> i;
        push(v, (f == 1 && i == 0), 1);
        push(v, 1'b0, 1);
      end
      for (int i = 6; i > 0; i--) begin
        v = 8'h80 >> i;
        push(v, 1'b0, 2);
      end
    end
    push(8'h80, 1'b1, 1);
    run_check("bounce");
  endtask

  task automatic test_breathe();
    int unsigned c;
    int m, d, li, ph;
    logic [7:0] v;
    logic fd;
    bus.mode = MODE_BREATHE;
    bus.step_period = 16'd1;
    c = edge_cnt;
    push(8'h00, 1'b0, 2);
    for (int j = 0; j < 248 + 5; j++) begin
      m  = j % 31;
      d  = (m <= 15) ? m : 30 - m;
      li = 7 - ((j / 31) % 8);
      ph = int'((c + 2 + j) % 16);
      v  = (ph < d) ? (8'h01 << li) : 8'h00;
      fd = (m == 30 && li == 0);
      push(v, fd, 1);
    end
    run_check("breathe");
  endtask

  task automatic test_mode_switch();
    bus.mode = MODE_CHASE;
    bus.step_period = 16'd3;
    push(8'h00, 1'b0, 1);
    push(8'h80, 1'b0, 3);
    push(8'h40, 1'b0, 3);
    push(8'h20, 1'b0, 1);
    run_check("switch_chase");
    bus.mode = MODE_FILL;
    push(8'h00, 1'b0, 1);
    push(8'h80, 1'b0, 3);
    push(8'hC0, 1'b0, 1);
    run_check("switch_fill");
  endtask

  task automatic test_period_zero();
    bus.mode = MODE_CHASE;
    bus.step_period = 16'd0;
    push(8'h00, 1'b0, 1);
    for (int i = 0; i < 8; i++)
      push(8'h80 >> i, 1'b0, 1);
    push(8'h80, 1'b1, 1);
    push(8'h40, 1'b0, 1);
    run_check("period_zero");
  endtask

  task automatic test_lower_period();
    bus.mode = MODE_BOUNCE;
    bus.step_period = 16'd100;
    push(8'h00, 1'b0, 1);
    push(8'h80, 1'b0, 51);
    run_check("period_100");
    bus.step_period = 16'd2;
    push(8'h40, 1'b0, 2);
    push(8'h20, 1'b0, 1);
    run_check("period_lowered");
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.led_out !== 8'h00 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: led_out=%h frame_done=%b, expected 00/0",
               bus.led_out, bus.frame_done);
    end
    bus.mode = MODE_CHASE;
    bus.step_period = 16'd1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      push(8'h80 >> i, 1'b0, 1);
    push(8'h80, 1'b1, 1);
    run_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_chase();
    test_fill();
    test_bounce();
    test_breathe();
    test_mode_switch();
    test_period_zero();
    test_lower_period();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_animator.md
# led_animator

Parametrised LED pattern engine that drives an `N_LEDS`-wide LED bank in four selectable animations: chase, fill/drain, bounce and PWM breathe. A run-time programmable step period replaces fixed timer loads. It is the next generation of the single-bank 8-LED animation top. The block sits between the board-level mode selector and the LED pins, and emits a frame-complete pulse for the system sequencer.

## Interface
- `N_LEDS`, default 8: number of LEDs; legal range is 2 or more.
- `STEP_W`, default 16: width of the step-period input.
- `PWM_W`, default 4: PWM counter and duty width. `D_MAX = 2**PWM_W - 1`.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `mode`  in  2: 0 CHASE, 1 FILL, 2 BOUNCE, 3 BREATHE. Sampled every cycle.
- `step_period`  in  STEP_W: clock cycles per animation step. The value 0 is treated as 1. Sampled live.
- `led_out`  out  N_LEDS: registered LED drive. Bit N_LEDS-1 is the MSB/"first" LED.
- `frame_done`  out  1: registered one-cycle pulse marking completion of one full animation cycle.

## Operation
- **Reset values:** `led_out`=0, `frame_done`=0, `mode_r`=0, `restart`=1, step count=0, duty=0, direction=up, breathe index=N_LEDS-1, PWM counter=0.
- **Mode change** (`mode != mode_r`) has top priority:
  - `mode_r<=mode`, `led_out<=0`, `restart<=1`, step count cleared.
  - No tick and no `frame_done` in that cycle.
- **Restart** (`restart`=1 with no mode change): load the initial pattern, clear the step count and set `restart<=0`.
  - CHASE, FILL, BOUNCE: initial pattern is MSB only.
  - BREATHE: `led_out`=0, duty=0, direction up, index N_LEDS-1.
- **Step tick:** asserted when step count ≥ max(`step_period`,1)-1; the count then returns to 0, otherwise it increments. A tick is suppressed during restart or mode change.
- **CHASE:** on each tick, shift right by one. When the pattern equals the LSB, the tick loads the MSB and pulses `frame_done`. Period is N_LEDS steps.
- **FILL:** fill phase shifts right, inserting 1 at the MSB, until all bits are 1. Drain phase shifts right, inserting 0, until all bits are 0. The tick from all-zero loads the MSB and pulses `frame_done`. Period is 2·N_LEDS steps.
- **BOUNCE:** a single lit bit moves toward the LSB, then reverses toward the MSB.
  - Direction flips on the tick that reaches the LSB or MSB.
  - The tick that arrives back at the MSB pulses `frame_done`.
  - Period is 2·N_LEDS-2 steps.
- **BREATHE:** a free-running PWM counter counts 0..D_MAX. `pwm = (pwm_cnt < duty)`.
  - Each cycle, `led_out[index]<=pwm`; all other bits are 0.
  - Tick, direction up: duty+1. On the tick where duty==D_MAX, set duty<=D_MAX-1 and direction down.
  - Tick, direction down, duty>0: duty-1.
  - Tick, direction down, duty==0: index-1 (wrapping from 0 to N_LEDS-1) and direction up. If the index wrapped, pulse `frame_done`.
  - Each LED therefore takes 2·D_MAX+1 ticks.
- **Arithmetic:** the step count is STEP_W bits, compared unsigned. The index is $clog2(N_LEDS) bits.

## Timing
- `led_out` and `frame_done` are both registered. `frame_done` is high in the same cycle `led_out` first shows the wrapped pattern.
- After reset release, the first edge loads the initial pattern. The first step is visible max(P,1) cycles later.
- On a mode change seen at edge t:
  - `led_out`=0 after edge t.
  - The initial pattern appears after edge t+1.
  - The first step occurs P cycles after that.
- If `step_period` is lowered below the current count, the tick fires on the next cycle.
- An asynchronous reset mid-animation returns all state to the reset values immediately.

## Structure
- Package `led_anim_pkg`: mode constants `MODE_CHASE`/`MODE_FILL`/`MODE_BOUNCE`/`MODE_BREATHE` and the 2-bit mode typedef.
- Sub-module `led_step_timer` (`STEP_W`): inputs `clk`, `rst`, `clear`, `period`; output `tick`. Implements the clamp-to-1 and the ≥ comparison.
- The PWM comparator, pattern registers and FSM live in `led_animator`.

## Test plan
- **CHASE** (N=8, P=3, release reset at mode 0) → `led_out` 0x80, 0x40, …, 0x01, 0x80 with 3 cycles per value. `frame_done` pulses every 24 cycles.
- **FILL** (P=1) → 0x80, 0xC0, …, 0xFF, 0x7F, …, 0x01, 0x00, 0x80. `frame_done` fires once per 16 cycles.
- **BOUNCE** (P=2) → 0x80 … 0x01 … 0x80 over 28 cycles, with no repeated value at either end. `frame_done` pulses on the return to 0x80.
- **BREATHE** (PWM_W=4, P=1) → bit 7 high for duty/16 of each PWM period. Duty goes 0→15→0 over 31 ticks, then the index moves to bit 6. `frame_done` fires after 248 ticks.
- **Mode switch** from CHASE at 0x20 to FILL → `led_out`=0x00 for one cycle, then 0x80. There is no `frame_done` pulse and the step count restarts.
- **Boundary:** with `step_period`=0, the block behaves as P=1. Lowering P from 100 to 2 at count 50 gives a tick on the next cycle. Asserting `rst` mid-frame gives `led_out`=0 immediately.
